// File: rtl/mem_read_sched_if.sv
// Bundle of the readout-scheduler handshake: start/BX/entry-count request side
// and the read-enable/address/mux-select response side.
interface mem_read_sched_if;
   logic        start;
   logic [2:0]  bx_in;
   logic [71:0] nent;
   logic        stall;
   logic [11:0] read_en;
   logic [5:0]  read_add;
   logic [3:0]  sel;
   logic [2:0]  bx_out;
   logic        busy;
   logic        done;

   modport master (
      output start, bx_in, nent, stall,
      input  read_en, read_add, sel, bx_out, busy, done
   );

   modport slave (
      input  start, bx_in, nent, stall,
      output read_en, read_add, sel, bx_out, busy, done
   );
endinterface

// File: rtl/mem_read_sched.sv
// Round-robin read scheduler over 12 memory ports, one entry per grant.
// Define MEM_READ_SCHED_TIMEOUT_EN to cap each readout at TIMEOUT ARB cycles.
module mem_read_sched #(
   parameter int TIMEOUT = 100,
   parameter int RD_LAT  = 2
) (
   input logic             clk,
   input logic             reset,
   mem_read_sched_if.slave bus
);

   localparam int NP = 12;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  rem_q [NP];
   logic [5:0]  rem_d [NP];
   logic [5:0]  ptr_q [NP];
   logic [5:0]  ptr_d [NP];
   logic [3:0]  rr_q, rr_d;
   logic [2:0]  bx_q, bx_d;
   logic [11:0] read_en_q, read_en_d;
   logic [5:0]  read_add_q, read_add_d;
   logic [3:0]  gcode_q, gcode_d;
   logic [2:0]  gbx_q, gbx_d;
   logic [3:0]  sel_pipe_q [RD_LAT];
   logic [3:0]  sel_pipe_d [RD_LAT];
   logic [2:0]  bx_pipe_q [RD_LAT];
   logic [2:0]  bx_pipe_d [RD_LAT];
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [NP-1:0] pend;
   logic          grant_vld;
   logic [3:0]    grant_idx;
   logic          tmo_hit;

   generate
      for (genvar gi = 0; gi < NP; gi++) begin : g_pend
         assign pend[gi] = (rem_q[gi] != 6'd0);
      end
   endgenerate

`ifdef MEM_READ_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // First pending port at or after rr, wrapping modulo 12.
   always_comb begin
      logic [4:0] sum;
      grant_vld = 1'b0;
      grant_idx = 4'd0;
      sum       = 5'd0;
      for (int k = 0; k < NP; k++) begin
         sum = {1'b0, rr_q} + 5'(k);
         if (sum >= 5'd12) sum = sum - 5'd12;
         if (!grant_vld && pend[sum[3:0]]) begin
            grant_vld = 1'b1;
            grant_idx = sum[3:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      ptr_d      = ptr_q;
      rr_d       = rr_q;
      bx_d       = bx_q;
      read_en_d  = 12'd0;
      read_add_d = read_add_q;
      gcode_d    = 4'd0;
      gbx_d      = bx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef MEM_READ_SCHED_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif

      // The select pipeline models memory latency, so it never stalls.
      sel_pipe_d[0] = gcode_q;
      bx_pipe_d[0]  = gbx_q;
      for (int k = 1; k < RD_LAT; k++) begin
         sel_pipe_d[k] = sel_pipe_q[k-1];
         bx_pipe_d[k]  = bx_pipe_q[k-1];
      end

      case (state_q)
         S_IDLE: busy_d = 1'b0;
         S_ARB: begin
            if (grant_vld && !bus.stall) begin
               read_en_d           = 12'd1 << grant_idx;
               read_add_d          = ptr_q[grant_idx];
               ptr_d[grant_idx]    = ptr_q[grant_idx] + 6'd1;
               rem_d[grant_idx]    = rem_q[grant_idx] - 6'd1;
               rr_d                = (grant_idx == 4'd11) ? 4'd0 : grant_idx + 4'd1;
               gcode_d             = (grant_idx < 4'd9) ? grant_idx + 4'd1 : grant_idx + 4'd2;
            end
            if (!(|pend) || tmo_hit) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
`ifdef MEM_READ_SCHED_TIMEOUT_EN
            tmo_d = tmo_q + TW'(1);
`endif
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A new start always wins, including over the final grant of a readout.
      if (bus.start) begin
         for (int i = 0; i < NP; i++) begin
            rem_d[i] = bus.nent[6*i +: 6];
            ptr_d[i] = 6'd0;
         end
         rr_d      = 4'd0;
         bx_d      = bus.bx_in;
         state_d   = S_ARB;
         busy_d    = 1'b1;
         done_d    = 1'b0;
         read_en_d = 12'd0;
         gcode_d   = 4'd0;
`ifdef MEM_READ_SCHED_TIMEOUT_EN
         tmo_d     = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rem_q      <= '{default: '0};
         ptr_q      <= '{default: '0};
         rr_q       <= 4'd0;
         bx_q       <= 3'd0;
         read_en_q  <= 12'd0;
         read_add_q <= 6'd0;
         gcode_q    <= 4'd0;
         gbx_q      <= 3'd0;
         sel_pipe_q <= '{default: '0};
         bx_pipe_q  <= '{default: '0};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MEM_READ_SCHED_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         ptr_q      <= ptr_d;
         rr_q       <= rr_d;
         bx_q       <= bx_d;
         read_en_q  <= read_en_d;
         read_add_q <= read_add_d;
         gcode_q    <= gcode_d;
         gbx_q      <= gbx_d;
         sel_pipe_q <= sel_pipe_d;
         bx_pipe_q  <= bx_pipe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef MEM_READ_SCHED_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign bus.read_en  = read_en_q;
   assign bus.read_add = read_add_q;
   assign bus.sel      = sel_pipe_q[RD_LAT-1];
   assign bus.bx_out   = bx_pipe_q[RD_LAT-1];
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_mem_read_sched.sv
// Scoreboard bench for mem_read_sched: directed readouts push expected grants
// and selects; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_read_sched;
   localparam int RD_LAT  = 2;
   localparam int TIMEOUT = 100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_read_sched_if bus_if();

   mem_read_sched #(.TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [17:0] exp_rd [$];
   logic [6:0]  exp_sel [$];
   int          rd_cyc [$];
   logic [3:0]  code_tab [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                  4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_rd(input int p, input int add);
      exp_rd.push_back({12'(1 << p), 6'(add)});
   endtask

   task automatic push(input int p, input int add, input int bx);
      push_rd(p, add);
      exp_sel.push_back({code_tab[p], 3'(bx)});
   endtask

   // Monitor: one line per observed grant or select.
   always @(negedge clk) begin
      logic [17:0] e;
      logic [6:0]  s;
      int          c;
      cyc++;
      if (bus_if.read_en != 12'd0) begin
         $display("grant en=%03h add=%0d", bus_if.read_en, bus_if.read_add);
         if (exp_rd.size() == 0) chk("extra_grant", int'(bus_if.read_en), 0);
         else begin
            e = exp_rd.pop_front();
            chk("grant", int'({bus_if.read_en, bus_if.read_add}), int'(e));
         end
         rd_cyc.push_back(cyc);
      end
      if (bus_if.sel != 4'd0) begin
         $display("sel=%0d bx=%0d", bus_if.sel, bus_if.bx_out);
         if (exp_sel.size() == 0) chk("extra_sel", int'(bus_if.sel), 0);
         else begin
            s = exp_sel.pop_front();
            chk("sel_bx", int'({bus_if.sel, bus_if.bx_out}), int'(s));
         end
         if (rd_cyc.size() == 0) chk("sel_orphan", int'(bus_if.sel), 0);
         else begin
            c = rd_cyc.pop_front();
            chk("sel_latency", cyc - c, RD_LAT);
         end
      end
      if (bus_if.done) done_cnt++;
   end

   task automatic do_start(input logic [71:0] n, input logic [2:0] bx);
      bus_if.nent  = n;
      bus_if.bx_in = bx;
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.nent  = '0;
   endtask

   task automatic wait_done(input int c0, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt > c0) break;
      end
      if (i >= bound) chk("done_timeout", done_cnt - c0, 1);
   endtask

   task automatic finish_test(input int c0, input int exp_done);
      repeat (RD_LAT + 3) @(negedge clk);
      #1;
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("sel_queue_drained", exp_sel.size(), 0);
      chk("done_pulses", done_cnt - c0, exp_done);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read_en"}, int'(bus_if.read_en), 0);
      chk({tag, "_read_add"}, int'(bus_if.read_add), 0);
      chk({tag, "_sel"}, int'(bus_if.sel), 0);
      chk({tag, "_bx_out"}, int'(bus_if.bx_out), 0);
      chk({tag, "_busy"}, int'(bus_if.busy), 0);
      chk({tag, "_done"}, int'(bus_if.done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [71:0] n;
      int c0;
      int ngr;
      bus_if.start = 1'b0;
      bus_if.stall = 1'b0;
      bus_if.nent  = '0;
      bus_if.bx_in = 3'd0;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Port 0 x2, port 11 x1, BX 5.
      n = '0; n[5:0] = 6'd2; n[71:66] = 6'd1;
      push(0, 0, 5); push(11, 0, 5); push(0, 1, 5);
      c0 = done_cnt;
      do_start(n, 3'd5);
      #1;
      chk("busy_after_start", int'(bus_if.busy), 1);
      chk("no_grant_yet", int'(bus_if.read_en), 0);
      @(negedge clk);
      #1;
      chk("first_grant", int'(bus_if.read_en), 12'h001);
      wait_done(c0, 50);
      chk("busy_in_done", int'(bus_if.busy), 0);
      finish_test(c0, 1);

      // Ports 8, 9, 10: codes 9, 11, 12.
      n = '0; n[53:48] = 6'd1; n[59:54] = 6'd1; n[65:60] = 6'd1;
      push(8, 0, 2); push(9, 0, 2); push(10, 0, 2);
      c0 = done_cnt;
      do_start(n, 3'd2);
      wait_done(c0, 50);
      finish_test(c0, 1);

      // Stall for 3 cycles after two grants from port 3.
      n = '0; n[23:18] = 6'd5;
      for (int k = 0; k < 5; k++) push(3, k, 1);
      c0 = done_cnt;
      do_start(n, 3'd1);
      repeat (2) @(negedge clk);
      bus_if.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("stall_read_en", int'(bus_if.read_en), 0);
      end
      bus_if.stall = 1'b0;
      chk("stall_sel_gap", int'(bus_if.sel), 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         chk("stall_sel_gap", int'(bus_if.sel), 0);
      end
      wait_done(c0, 50);
      finish_test(c0, 1);

      // Restart mid-ARB on the same port: pointer restarts, no done for old BX.
      n = '0; n[5:0] = 6'd10;
      push(0, 0, 3); push(0, 1, 3); push(0, 2, 3);
      c0 = done_cnt;
      do_start(n, 3'd3);
      repeat (3) @(negedge clk);
      n = '0; n[5:0] = 6'd2;
      push(0, 0, 6); push(0, 1, 6);
      do_start(n, 3'd6);
      wait_done(c0, 50);
      finish_test(c0, 1);

      // Start coincides with the final grant: grant dropped, no done.
      n = '0; n[5:0] = 6'd2;
      push(0, 0, 4);
      c0 = done_cnt;
      do_start(n, 3'd4);
      @(negedge clk);
      n = '0; n[11:6] = 6'd1;
      push(1, 0, 1);
      do_start(n, 3'd1);
      wait_done(c0, 50);
      finish_test(c0, 1);

      // All counts zero: one ARB cycle, then done.
      c0 = done_cnt;
      do_start('0, 3'd7);
      #1;
      chk("zero_busy", int'(bus_if.busy), 1);
      chk("zero_done_early", int'(bus_if.done), 0);
      @(negedge clk);
      #1;
      chk("zero_done", int'(bus_if.done), 1);
      chk("zero_busy_off", int'(bus_if.busy), 0);
      wait_done(c0, 10);
      finish_test(c0, 1);

      // Reset mid-ARB, then a normal readout.
      n = '0; n[17:12] = 6'd6;
      push_rd(2, 0); push_rd(2, 1);
      c0 = done_cnt;
      do_start(n, 3'd3);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk_all_zero("mid_reset");
      reset = 1'b0;
      rd_cyc.delete();
      finish_test(c0, 0);
      n = '0; n[17:12] = 6'd1;
      push(2, 0, 2);
      c0 = done_cnt;
      do_start(n, 3'd2);
      wait_done(c0, 50);
      finish_test(c0, 1);

      // Every port full.
`ifdef MEM_READ_SCHED_TIMEOUT_EN
      ngr = TIMEOUT;
`else
      ngr = 756;
`endif
      n = {12{6'd63}};
      for (int i = 0; i < ngr; i++) push(i % 12, i / 12, 0);
      c0 = done_cnt;
      do_start(n, 3'd0);
      wait_done(c0, 2000);
      finish_test(c0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_read_sched.md
MEM_READ_SCHED -- requirements
Module: mem_read_sched

Interface
REQ-001 Parameter TIMEOUT, default 100: maximum ARB cycles per BX when MEM_READ_SCHED_TIMEOUT_EN is defined.
REQ-002 Parameter RD_LAT, default 2: memory read latency in clocks, from read_en/read_add to data at the mux input.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that opens a new BX readout.
REQ-006 bx_in  in  3  BX number of the readout being opened.
REQ-007 nent  in  72  entry count per port; port i occupies bits [6i+5:6i]; sampled only on start.
REQ-008 stall  in  1  downstream not ready; freezes grants.
REQ-009 read_en  out  12  one-hot memory read enable; bit i selects port i.
REQ-010 read_add  out  6  read address for the granted port.
REQ-011 sel  out  4  binary mux select, aligned with memory data; 0 means idle.
REQ-012 bx_out  out  3  latched BX, aligned with sel.
REQ-013 busy  out  1  high while in ARB.
REQ-014 done  out  1  one-cycle pulse at the end of a readout.

Function
REQ-015 The state machine SHALL have three states, IDLE, ARB and DONE: IDLE->ARB on start; ARB->DONE when no port has remaining entries (or on timeout); DONE->IDLE unconditionally after one cycle.
REQ-016 On start (in any state, including mid-ARB, which aborts the current readout), the block SHALL load rem[i]=nent[i], ptr[i]=0, the round-robin pointer rr=0 and bx=bx_in, then enter ARB on the next cycle.
REQ-017 In ARB with stall=0, the grant g SHALL be the first port with rem[g]>0 searched circularly from rr; then read_en=1<<g, read_add=ptr[g], ptr[g]+=1, rem[g]-=1, rr=(g+1) mod 12, all registered, so one entry is read per grant.
REQ-018 With stall=1, or when no port is granted, read_en SHALL be 0, read_add SHALL hold, and rem, ptr and rr SHALL be unchanged.
REQ-019 Port code map for sel: ports 0-8 -> 1-9, ports 9-11 -> 11-13; codes 0, 10, 14 and 15 are never issued for a grant.
REQ-020 sel and bx_out SHALL pass through an RD_LAT-stage pipeline that shifts every cycle regardless of stall; a stage without a grant carries sel=0.
REQ-021 The first grant SHALL appear one cycle after start; its sel SHALL appear RD_LAT cycles after its read_en.
REQ-022 If all nent values are 0, ARB SHALL issue no grant and move to DONE after one cycle.
REQ-023 The ptr and rem arithmetic SHALL be 6-bit unsigned; rem never decrements below 0 and ptr never exceeds the value of nent latched at start.
REQ-024 done SHALL pulse in the DONE state; busy=0 in IDLE and DONE.
REQ-025 If start and the final grant fall in the same cycle, start SHALL win and done SHALL not pulse.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL enter IDLE and clear read_en, read_add, sel pipeline, bx_out, busy, done, rem, ptr, rr and the timeout counter to 0.
REQ-027 reset SHALL override start in the same cycle.

Configuration
REQ-028 With MEM_READ_SCHED_TIMEOUT_EN defined, a counter cleared on start SHALL count ARB cycles and force ARB->DONE after TIMEOUT cycles, discarding any remaining entries.
REQ-029 Without MEM_READ_SCHED_TIMEOUT_EN, the block SHALL stay in ARB until all rem are 0, and the TIMEOUT parameter SHALL be ignored.

Verification
REQ-030 nent port0=2, port11=1, others 0, start with bx_in=5 -> read_en 0x001/add 0, 0x800/add 0, 0x001/add 1; sel 1,13,1 two cycles later with bx_out=5; done pulses.
REQ-031 Ports 8, 9 and 10 each with 1 entry -> sel sequence 9,11,12; code 10 is never seen.
REQ-032 stall held high for 3 cycles mid-readout -> read_en=0 for those 3 cycles, 3 zero sel slots, no entry lost or duplicated.
REQ-033 start reasserted mid-ARB with new nent -> old readout aborted, ptr restarts at 0, no done pulse for the aborted BX.
REQ-034 Timeout enabled, TIMEOUT=100, all ports nent=63 -> exactly 100 grants, then done; disabled -> 756 grants, then done.
REQ-035 reset asserted mid-ARB -> next cycle all outputs 0 and IDLE; a later start works normally.
